// File: rtl/ex_execute_unit.sv
// ex_execute_unit: RV32IM EX-stage ALU with single-cycle base ops and iterative M-extension FSM.
// Define FAST_MUL_EN to route MUL-class ops through a one-cycle combinational multiplier.
module ex_execute_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [3:0]      alu_control,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            out_valid,
    output logic            busy
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_hi, r_lo, r_mc;
    logic [1:0]        r_op;
    logic              r_neg;
    logic              w_acc, w_is_it, w_sa, w_sb, w_neg, w_slt;
    logic [XLEN-1:0]   w_ma, w_mb, w_base, w_quick, w_nhi, w_nlo, w_dq, w_dqn, w_ires;
    logic [XLEN:0]     w_sum, w_sh, w_dif;
    logic [2*XLEN-1:0] w_p, w_pn;

    assign busy  = (r_state == S_MUL) || (r_state == S_DIV);
    assign zero  = (result == '0);
    assign w_acc = in_valid && !busy && !flush;

    // Signedness of each operand: DIV/REM use bit0, MUL family uses the low two code bits
    assign w_sa  = alu_control[2] ? (!alu_control[0] && op_a[XLEN-1]) : ((alu_control[1:0] != 2'b11) && op_a[XLEN-1]);
    assign w_sb  = alu_control[2] ? (!alu_control[0] && op_b[XLEN-1]) : (!alu_control[1] && op_b[XLEN-1]);
    assign w_ma  = w_sa ? -op_a : op_a;
    assign w_mb  = w_sb ? -op_b : op_b;
    // Division by zero keeps the all-ones quotient unnegated; remainder follows dividend sign
    assign w_neg = alu_control[2] ? (alu_control[1] ? w_sa : ((w_sa ^ w_sb) && (op_b != '0))) : (w_sa ^ w_sb);

    assign w_slt  = $signed(op_a) < $signed(op_b);
    assign w_base = (alu_control == 4'b0010) ? op_a + op_b :
                    (alu_control == 4'b0110) ? op_a - op_b :
                    (alu_control == 4'b0000) ? op_a & op_b :
                    (alu_control == 4'b0001) ? op_a | op_b :
                    (alu_control == 4'b0111) ? {{(XLEN-1){1'b0}}, w_slt} : '0;

`ifdef FAST_MUL_EN
    logic [2*XLEN-1:0] w_fp;
    assign w_fp    = $signed({{XLEN{w_sa}}, op_a}) * $signed({{XLEN{w_sb}}, op_b});
    assign w_quick = alu_control[3] ? ((alu_control[1:0] == 2'b00) ? w_fp[XLEN-1:0] : w_fp[2*XLEN-1:XLEN]) : w_base;
    assign w_is_it = alu_control[3] && alu_control[2];
`else
    assign w_quick = w_base;
    assign w_is_it = alu_control[3];
`endif

    // One shift-add step (MUL) or one restoring subtract-shift step (DIV)
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : '0);
    assign w_sh  = {r_hi, r_lo[XLEN-1]};
    assign w_dif = w_sh - {1'b0, r_mc};
    assign w_nhi = (r_state == S_MUL) ? w_sum[XLEN:1] : (w_dif[XLEN] ? w_sh[XLEN-1:0] : w_dif[XLEN-1:0]);
    assign w_nlo = (r_state == S_MUL) ? {w_sum[0], r_lo[XLEN-1:1]} : {r_lo[XLEN-2:0], !w_dif[XLEN]};

    assign w_p    = {w_nhi, w_nlo};
    assign w_pn   = r_neg ? -w_p : w_p;
    assign w_dq   = r_op[1] ? w_nhi : w_nlo;
    assign w_dqn  = r_neg ? -w_dq : w_dq;
    assign w_ires = (r_state == S_MUL) ? ((r_op == 2'b00) ? w_pn[XLEN-1:0] : w_pn[2*XLEN-1:XLEN]) : w_dqn;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mc      <= '0;
            r_op      <= '0;
            r_neg     <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            out_valid <= 1'b0;
        end else if (busy) begin
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_W'(XLEN-1)) begin
                r_state   <= S_DONE;
                result    <= w_ires;
                out_valid <= 1'b1;
            end
        end else begin
            r_cnt     <= '0;
            out_valid <= w_acc && !w_is_it;
            r_state   <= (w_acc && w_is_it) ? (alu_control[2] ? S_DIV : S_MUL) : S_IDLE;
            if (w_acc && !w_is_it)
                result <= w_quick;
            if (w_acc && w_is_it) begin
                r_hi  <= '0;
                r_lo  <= alu_control[2] ? w_ma : w_mb;
                r_mc  <= alu_control[2] ? w_mb : w_ma;
                r_op  <= alu_control[1:0];
                r_neg <= w_neg;
            end
        end
    end
endmodule

// File: tb/tb_ex_execute_unit.sv
// tb_ex_execute_unit: directed vector table, flush/reset sequences and randomized ops vs. an arithmetic model.
module tb_ex_execute_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  alu_control = 4'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic [31:0] result;
    logic        zero, out_valid, busy;

    int total = 0;
    int bad = 0;
    logic [31:0] last_res = '0;

    ex_execute_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_control(alu_control),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .result(result), .zero(zero), .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        string       nm;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ubb = {32'b0, b};
        case (c)
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: begin p = sa * sb; return p[31:0]; end
            4'b1001: begin p = sa * sb; return p[63:32]; end
            4'b1010: begin p = sa * ub; return p[63:32]; end
            4'b1011: begin p = ua * ubb; return p[63:32]; end
            4'b1100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return $signed(a) / $signed(b);
            end
            4'b1101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            4'b1110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            4'b1111: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // Issue one op, then watch busy/out_valid every cycle; inputs are scrambled and in_valid
    // is held high while busy to prove operand capture and that busy blocks acceptance.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string nm);
        int lat = c[3] ? 33 : 1;
        int badc = 0;
        logic [31:0] got_r = '0;
        logic        got_z = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; alu_control = c; op_a = a; op_b = b;
        for (int j = 1; j <= lat + 1; j++) begin
            @(posedge clk); #1;
            if ((busy !== (j < lat)) || (out_valid !== (j == lat)))
                if (badc == 0) badc = j;
            if (j == lat) begin got_r = result; got_z = zero; end
            in_valid = (j < lat);
            alu_control = 4'($urandom);
            op_a = $urandom;
            op_b = $urandom;
        end
        in_valid = 1'b0;
        total++;
        if (badc != 0) begin
            bad++;
            $display("FAIL %s timing: first wrong cycle %0d, want out_valid only at cycle %0d", nm, badc, lat);
        end
        chk({nm, " result"}, got_r, exp);
        chk({nm, " zero"}, {31'b0, got_z}, {31'b0, exp == 0});
        last_res = exp;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        logic [3:0] codes[16];
        int badc;
        logic [31:0] prev;

        vt.push_back('{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, "add_ovf"});
        vt.push_back('{4'b0110, 32'd5,        32'd5,        32'h00000000, "sub_zero"});
        vt.push_back('{4'b0111, 32'hFFFFFFFF, 32'd1,        32'h00000001, "slt_neg"});
        vt.push_back('{4'b0111, 32'd1,        32'hFFFFFFFF, 32'h00000000, "slt_pos"});
        vt.push_back('{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, "and"});
        vt.push_back('{4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, "or"});
        vt.push_back('{4'b0011, 32'h12345678, 32'h1,        32'h00000000, "code3"});
        vt.push_back('{4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "mulh_m1"});
        vt.push_back('{4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max"});
        vt.push_back('{4'b1000, 32'd6,        32'd7,        32'd42,       "mul_6x7"});
        vt.push_back('{4'b1010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "mulhsu"});
        vt.push_back('{4'b1100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2"});
        vt.push_back('{4'b1110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2"});
        vt.push_back('{4'b1101, 32'h00001234, 32'd0,        32'hFFFFFFFF, "divu_by0"});
        vt.push_back('{4'b1111, 32'd9,        32'd0,        32'd9,        "remu_by0"});
        vt.push_back('{4'b1100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"});
        vt.push_back('{4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf"});
        vt.push_back('{4'b1100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, "div_neg_by0"});
        vt.push_back('{4'b1110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, "rem_neg_by0"});
        vt.push_back('{4'b1101, 32'd100,      32'd7,        32'd14,       "divu_100_7"});

        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result, 32'h0);
        chk("reset zero", {31'b0, zero}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vt[i]) run_op(vt[i].c, vt[i].a, vt[i].b, vt[i].e, vt[i].nm);

        // Flush DIV at cycle 10, then an ADD accepted at cycle 11 completes at cycle 12
        prev = last_res;
        badc = 0;
        @(negedge clk);
        in_valid = 1'b1; alu_control = 4'b1100; op_a = 32'd100; op_b = 32'd7;
        for (int j = 1; j <= 45; j++) begin
            @(posedge clk); #1;
            if ((busy !== (j <= 10)) || (out_valid !== (j == 12)))
                if (badc == 0) badc = j;
            if (j == 11) chk("flush hold result", result, prev);
            if (j == 12) chk("flush next add", result, 32'd30);
            flush = (j == 10);
            in_valid = (j == 11);
            alu_control = 4'b0010; op_a = 32'd10; op_b = 32'd20;
        end
        total++;
        if (badc != 0) begin
            bad++;
            $display("FAIL flush timing: first wrong cycle %0d", badc);
        end
        last_res = 32'd30;

        // Flush together with in_valid drops the op
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; alu_control = 4'b0010; op_a = 32'd1; op_b = 32'd2;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush+valid out_valid", {31'b0, out_valid}, 32'd0);
        chk("flush+valid result", result, 32'd30);
        @(posedge clk); #1;
        chk("flush+valid later out_valid", {31'b0, out_valid}, 32'd0);

        // rst at cycle 20 of DIVU, with ignored in_valid traffic while busy
        badc = 0;
        @(negedge clk);
        in_valid = 1'b1; alu_control = 4'b1101; op_a = 32'd1000; op_b = 32'd3;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk); #1;
            if ((busy !== (j <= 20)) || (out_valid !== 1'b0))
                if (badc == 0) badc = j;
            if (j == 21) begin
                chk("rst mid result", result, 32'h0);
                chk("rst mid zero", {31'b0, zero}, 32'd1);
            end
            rst = (j == 20);
            in_valid = (j < 20);
            alu_control = 4'b0010; op_a = $urandom; op_b = $urandom;
        end
        in_valid = 1'b0;
        total++;
        if (badc != 0) begin
            bad++;
            $display("FAIL rst timing: first wrong cycle %0d", badc);
        end
        last_res = 32'h0;

        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                  4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  c = codes[$urandom_range(0, 15)];
            logic [31:0] a = pick_operand();
            logic [31:0] b = pick_operand();
            run_op(c, a, b, ref_op(c, a, b), $sformatf("rand%0d_op%b", n, c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
